regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter ZERO_REG, default 1; 1 = register 0 is hardwired zero (integer file), 0 = register 0 is writable (float file).
REQ-002 SHALL have parameter N_REQ, default 3, giving the number of writeback requesters: 0 = pipeline WB, 1 = mul/div unit, 2 = load/FPU.
REQ-003 SHALL have port clk, input, width 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, width N_REQ: per-requester write request.
REQ-006 SHALL have port req_rd, input, width 5*N_REQ: packed destination register, requester i at bits [5i+4:5i].
REQ-007 SHALL have port req_data, input, width 32*N_REQ: packed write data, requester i at bits [32i+31:32i].
REQ-008 SHALL have port req_ready, output, width N_REQ: one-hot grant; a request is accepted when its valid and ready bits are both 1.
REQ-009 SHALL have ports WE (width 1), A3 (width 5) and WD3 (width 32), all outputs, registered, driving the register file write port.
REQ-010 SHALL have ports rsv_valid (width 1) and rsv_rd (width 5), inputs, for a dispatch-time reservation of a destination register.
REQ-011 SHALL have port rsv_ready, output, width 1: the reservation is accepted this cycle.
REQ-012 SHALL have ports rs1 and rs2, inputs, width 5 each: source registers being read.
REQ-013 SHALL have ports hazard1 and hazard2, outputs, width 1 each: the corresponding source register is pending.

Function
REQ-014 SHALL assert at most one req_ready bit per cycle, and SHALL assert it only for a requester with req_valid=1.
REQ-015 SHALL use round-robin arbitration: the highest priority goes to the requester after the one granted last, wrapping from N_REQ-1 to 0; the pointer advances only on a grant.
REQ-016 SHALL compute req_ready combinationally in the same cycle as req_valid (zero-cycle grant).
REQ-017 The requester SHALL hold req_valid, req_rd and req_data stable until accepted; the arbiter MAY assume this holds.
REQ-018 SHALL register the accepted request, so that WE=1, A3=rd and WD3=data in the cycle after the grant, i.e. one cycle of latency; the register file commits on the edge that ends that cycle.
REQ-019 With ZERO_REG=1 and rd=0, SHALL still grant and consume the request, but SHALL drive WE=0 in the following cycle.
REQ-020 SHALL keep a 32-bit busy scoreboard: a bit is set when a reservation is accepted and cleared on the edge on which WE=1 with A3 equal to that register.
REQ-021 SHALL drive rsv_ready = !busy[rsv_rd]; the reservation is taken only when rsv_valid && rsv_ready.
REQ-022 With ZERO_REG=1, a reservation of register 0 SHALL be ready and SHALL NOT set a busy bit.
REQ-023 If a clear (WE with A3=r) and a reservation of r are accepted on the same edge, the reservation SHALL win and busy[r] SHALL remain 1.
REQ-024 SHALL drive hazard1 = busy[rs1] && !(WE && A3==rs1); hazard2 is defined identically for rs2. The exclusion is valid because the register file bypasses WD3 to the read ports.
REQ-025 With ZERO_REG=1, rs=0 SHALL never raise a hazard.
REQ-026 A write with no matching busy bit (no prior reservation) SHALL be legal and SHALL leave busy unchanged.

Reset
REQ-027 On a clk edge with rst=1, SHALL set WE=0, A3=0, WD3=0, busy = all zeros and the round-robin pointer to requester 0 (highest priority).
REQ-028 While rst=1, SHALL drive req_ready=0 and rsv_ready=0, and SHALL NOT accept requests or reservations.
REQ-029 A request that is pending when reset asserts SHALL be dropped; after reset it SHALL be re-arbitrated from the reset priority order.

Structure
REQ-030 SHALL place XLEN=32, REG_AW=5, N_REQ_DEFAULT=3 and the requester index constants (WB, MDU, LSU) in a shared package, rv_pkg.
REQ-031 SHALL implement round-robin selection as a sub-module, rr_arbiter: N-bit request in, one-hot grant out, pointer updated on a grant-enable input.
REQ-032 SHALL implement the scoreboard and the output registers inline in regfile_wb_arbiter.

Verification
REQ-033 Scenario: after reset, req_valid=3'b111 held for 3 cycles -> grants are 001, 010, 100 on successive cycles; WE is high in cycles 2-4.
REQ-034 Scenario: req 1 only, rd=5, data=0xDEADBEEF -> req_ready=010 in cycle 0; WE=1, A3=5, WD3=0xDEADBEEF in cycle 1.
REQ-035 Scenario: reserve rd=7, then rs1=7 -> hazard1=1 and rsv_ready for rd=7 is 0; write to 7 -> hazard1=0 in the WE cycle, busy[7]=0 afterwards.
REQ-036 Scenario: on one edge, WE with A3=9 and an accepted reservation of 9 -> busy[9]=1 and hazard persists.
REQ-037 Scenario: ZERO_REG=1, write rd=0 -> granted and WE=0; reserve 0 -> rsv_ready=1, no hazard on rs1=0. With ZERO_REG=0, the same write gives WE=1, A3=0.
REQ-038 Scenario: assert rst while req 2 is waiting with busy bits set -> next cycle WE=0 and busy=0; after release with req_valid=111, req 0 is granted first.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg
//   Shared constants for the writeback arbitration slice: datapath width,
//   register address width, default requester count and the fixed
//   requester indices used to connect the writeback sources.
//   No ports (package).
package rv_pkg;

  localparam int XLEN          = 32;
  localparam int REG_AW        = 5;
  localparam int N_REG         = 1 << REG_AW;
  localparam int N_REQ_DEFAULT = 3;

  // Requester slots on the arbiter; WB sits at index 0 so it has the
  // highest priority straight out of reset.
  localparam int WB  = 0;
  localparam int MDU = 1;
  localparam int LSU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter. The requester after the one granted last has the
//   highest priority; the pointer only moves when a grant is taken.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, pointer returns to requester 0
//   req    - N request bits
//   gnt_en - allow the pointer to advance on this cycle's grant
//   gnt    - one-hot grant (all zero when nothing is requested)
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         gnt_en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] sel;
  logic          found;
  int            idx;

  // Scan from the pointer upward with wraparound; the first set bit wins
  // and the next pointer is the slot just after it.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
        ptr_nxt  = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_en && found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates several writeback sources onto the single register file
//   write port and tracks which destination registers still have a write
//   in flight (busy scoreboard) so the read stage can detect hazards.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   req_valid/rd/data    - packed per-requester writeback requests
//   req_ready            - one-hot combinational grant
//   WE, A3, WD3          - registered register file write port
//   rsv_valid/rd/ready   - dispatch-time reservation of a destination
//   rs1, rs2             - source registers being read
//   hazard1, hazard2     - source register still waiting for its write
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int ZERO_REG = 1,
  parameter int N_REQ    = N_REQ_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [REG_AW*N_REQ-1:0] req_rd,
  input  logic [XLEN*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    WE,
  output logic [REG_AW-1:0]       A3,
  output logic [XLEN-1:0]         WD3,
  input  logic                    rsv_valid,
  input  logic [REG_AW-1:0]       rsv_rd,
  output logic                    rsv_ready,
  input  logic [REG_AW-1:0]       rs1,
  input  logic [REG_AW-1:0]       rs2,
  output logic                    hazard1,
  output logic                    hazard2
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [N_REQ-1:0]  arb_req;
  logic [N_REQ-1:0]  gnt;
  logic              grant_any;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic              wb_to_zero;

  logic [N_REG-1:0]  busy;
  logic [N_REG-1:0]  busy_clr;
  logic [N_REG-1:0]  busy_set;
  logic [N_REG-1:0]  busy_nxt;
  logic              rsv_take;

  // Masking requests during reset keeps the grant at zero and stops the
  // pointer from moving, so a pending request is simply dropped.
  assign arb_req = rst ? '0 : req_valid;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .gnt_en (!rst),
    .gnt    (gnt)
  );

  assign req_ready = gnt;
  assign grant_any = |gnt;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = req_rd[i*REG_AW +: REG_AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // A write to x0 in the integer file is still consumed, just never
  // presented to the register file.
  assign wb_to_zero = HAS_ZERO && (sel_rd == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      WE  <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else begin
      WE <= grant_any && !wb_to_zero;
      if (grant_any) begin
        A3  <= sel_rd;
        WD3 <= sel_data;
      end
    end
  end

  assign rsv_ready = !rst && !busy[rsv_rd];
  assign rsv_take  = rsv_valid && rsv_ready && !(HAS_ZERO && (rsv_rd == '0));

  // Set is OR-ed in after the clear so a reservation landing on the same
  // edge as the previous write to that register keeps the bit set.
  always_comb begin
    busy_clr = '0;
    busy_set = '0;
    if (WE) busy_clr[A3] = 1'b1;
    if (rsv_take) busy_set[rsv_rd] = 1'b1;
    busy_nxt = (busy & ~busy_clr) | busy_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // The register file forwards WD3 to its read ports, so a source being
  // written this very cycle is already satisfied.
  assign hazard1 = busy[rs1] && !(WE && (A3 == rs1)) && !(HAS_ZERO && (rs1 == '0));
  assign hazard2 = busy[rs2] && !(WE && (A3 == rs2)) && !(HAS_ZERO && (rs2 == '0));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        rsv_valid;
  logic [4:0]  rsv_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  logic [2:0]  ready_z, ready_f;
  logic        we_z, we_f;
  logic [4:0]  a3_z, a3_f;
  logic [31:0] wd3_z, wd3_f;
  logic        rsvr_z, rsvr_f;
  logic        hz1_z, hz1_f;
  logic        hz2_z, hz2_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ZERO_REG(1), .N_REQ(3)) dut_int (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(ready_z),
    .WE(we_z), .A3(a3_z), .WD3(wd3_z),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsvr_z),
    .rs1(rs1), .rs2(rs2), .hazard1(hz1_z), .hazard2(hz2_z)
  );

  regfile_wb_arbiter #(.ZERO_REG(0), .N_REQ(3)) dut_flt (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(ready_f),
    .WE(we_f), .A3(a3_f), .WD3(wd3_f),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsvr_f),
    .rs1(rs1), .rs2(rs2), .hazard1(hz1_f), .hazard2(hz2_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
    req_rd[i*5 +: 5]    = rd;
    req_data[i*32 +: 32] = data;
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge.
  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    rsv_valid = 1'b0; rsv_rd = '0; rs1 = '0; rs2 = '0;
    next_cycle(); next_cycle();

    // Reset: no grant or reservation while rst is high
    req_valid = 3'b111; rsv_valid = 1'b1; rsv_rd = 5'd3;
    set_req(0, 5'd1, 32'h1000_0000);
    set_req(1, 5'd2, 32'h1000_0001);
    set_req(2, 5'd3, 32'h1000_0002);
    mid();
    chk("rst_ready", {29'd0, ready_z}, 32'd0);
    chk("rst_rsv_ready", {31'd0, rsvr_z}, 32'd0);
    next_cycle(); mid();
    chk("rst_we", {31'd0, we_z}, 32'd0);
    chk("rst_a3", {27'd0, a3_z}, 32'd0);
    chk("rst_wd3", wd3_z, 32'd0);

    // Round robin with all three requesting
    next_cycle();
    rst = 1'b0; rsv_valid = 1'b0;
    mid();
    chk("rr_c0_ready", {29'd0, ready_z}, 32'b001);
    chk("rr_c0_we", {31'd0, we_z}, 32'd0);
    chk("rsv3_not_taken_in_rst", {31'd0, rsvr_z}, 32'd1);
    next_cycle(); mid();
    chk("rr_c1_ready", {29'd0, ready_z}, 32'b010);
    chk("rr_c1_we", {31'd0, we_z}, 32'd1);
    chk("rr_c1_a3", {27'd0, a3_z}, 32'd1);
    chk("rr_c1_wd3", wd3_z, 32'h1000_0000);
    next_cycle(); mid();
    chk("rr_c2_ready", {29'd0, ready_z}, 32'b100);
    chk("rr_c2_a3", {27'd0, a3_z}, 32'd2);
    next_cycle();
    req_valid = 3'b000;
    mid();
    chk("rr_c3_ready", {29'd0, ready_z}, 32'd0);
    chk("rr_c3_we", {31'd0, we_z}, 32'd1);
    chk("rr_c3_wd3", wd3_z, 32'h1000_0002);
    next_cycle(); mid();
    chk("rr_c4_we", {31'd0, we_z}, 32'd0);

    // Single requester 1
    next_cycle();
    req_valid = 3'b010; set_req(1, 5'd5, 32'hDEAD_BEEF);
    mid();
    chk("mdu_ready", {29'd0, ready_z}, 32'b010);
    next_cycle();
    req_valid = 3'b000;
    mid();
    chk("mdu_we", {31'd0, we_z}, 32'd1);
    chk("mdu_a3", {27'd0, a3_z}, 32'd5);
    chk("mdu_wd3", wd3_z, 32'hDEAD_BEEF);

    // Reserve 7, hazard, then write 7
    next_cycle();
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    mid();
    chk("rsv7_ready", {31'd0, rsvr_z}, 32'd1);
    next_cycle();
    rsv_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd7;
    req_valid = 3'b001; set_req(0, 5'd7, 32'h0000_0077);
    mid();
    chk("rs7_hazard1", {31'd0, hz1_z}, 32'd1);
    chk("rs7_hazard2", {31'd0, hz2_z}, 32'd1);
    chk("rsv7_busy", {31'd0, rsvr_z}, 32'd0);
    chk("wb7_ready", {29'd0, ready_z}, 32'b001);
    next_cycle();
    req_valid = 3'b000;
    mid();
    chk("wb7_we", {31'd0, we_z}, 32'd1);
    chk("wb7_a3", {27'd0, a3_z}, 32'd7);
    chk("wb7_bypass_hazard1", {31'd0, hz1_z}, 32'd0);
    chk("wb7_still_busy", {31'd0, rsvr_z}, 32'd0);
    next_cycle(); mid();
    chk("rs7_cleared", {31'd0, rsvr_z}, 32'd1);
    chk("rs7_no_hazard", {31'd0, hz1_z}, 32'd0);

    // Unreserved write to 9, reservation of 9 on the clearing edge
    next_cycle();
    req_valid = 3'b100; set_req(2, 5'd9, 32'h0000_0099);
    rs1 = 5'd9; rsv_rd = 5'd9;
    mid();
    chk("wb9_ready", {29'd0, ready_z}, 32'b100);
    chk("rsv9_free", {31'd0, rsvr_z}, 32'd1);
    next_cycle();
    req_valid = 3'b000; rsv_valid = 1'b1;
    mid();
    chk("wb9_we", {31'd0, we_z}, 32'd1);
    chk("wb9_a3", {27'd0, a3_z}, 32'd9);
    chk("rsv9_same_edge_ready", {31'd0, rsvr_z}, 32'd1);
    next_cycle();
    rsv_valid = 1'b0;
    mid();
    chk("rsv9_wins_busy", {31'd0, rsvr_z}, 32'd0);
    chk("rsv9_wins_hazard", {31'd0, hz1_z}, 32'd1);

    // Register 0 behaviour in both file types
    next_cycle();
    req_valid = 3'b001; set_req(0, 5'd0, 32'h0000_1234);
    rs1 = 5'd0; rs2 = 5'd9;
    mid();
    chk("x0_int_ready", {29'd0, ready_z}, 32'b001);
    chk("x0_flt_ready", {29'd0, ready_f}, 32'b001);
    next_cycle();
    req_valid = 3'b000; rsv_valid = 1'b1; rsv_rd = 5'd0;
    mid();
    chk("x0_int_we", {31'd0, we_z}, 32'd0);
    chk("x0_flt_we", {31'd0, we_f}, 32'd1);
    chk("x0_flt_a3", {27'd0, a3_f}, 32'd0);
    chk("x0_flt_wd3", wd3_f, 32'h0000_1234);
    chk("x0_int_rsv_ready", {31'd0, rsvr_z}, 32'd1);
    next_cycle();
    rsv_valid = 1'b0;
    mid();
    chk("x0_int_no_hazard", {31'd0, hz1_z}, 32'd0);
    chk("x0_int_rsv_ready2", {31'd0, rsvr_z}, 32'd1);
    chk("x0_flt_hazard", {31'd0, hz1_f}, 32'd1);
    chk("x0_flt_busy", {31'd0, rsvr_f}, 32'd0);
    chk("rs2_9_hazard", {31'd0, hz2_z}, 32'd1);

    // Reset with a pending request and busy bits set
    next_cycle();
    rst = 1'b1; req_valid = 3'b100; set_req(2, 5'd4, 32'h0000_0044);
    mid();
    chk("rst2_ready_int", {29'd0, ready_z}, 32'd0);
    chk("rst2_ready_flt", {29'd0, ready_f}, 32'd0);
    next_cycle();
    rst = 1'b0; req_valid = 3'b111;
    set_req(0, 5'd1, 32'h2000_0000);
    set_req(1, 5'd2, 32'h2000_0001);
    set_req(2, 5'd3, 32'h2000_0002);
    rsv_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd0;
    mid();
    chk("rst2_we", {31'd0, we_z}, 32'd0);
    chk("rst2_first_grant", {29'd0, ready_z}, 32'b001);
    chk("rst2_busy9_clear", {31'd0, rsvr_z}, 32'd1);
    chk("rst2_no_hazard9", {31'd0, hz1_z}, 32'd0);
    chk("rst2_flt_busy0_clear", {31'd0, hz2_f}, 32'd0);
    next_cycle();
    req_valid = 3'b000;
    mid();
    chk("rst2_wb_we", {31'd0, we_z}, 32'd1);
    chk("rst2_wb_a3", {27'd0, a3_z}, 32'd1);
    chk("rst2_wb_wd3", wd3_z, 32'h2000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
